// File: rtl/motor_drive_sequencer.sv
// -----------------------------------------------------------------------------
// motor_drive_sequencer
//   Two-wheel H-bridge drive sequencer. Captures the software PWM word and
//   direction bits into shadow registers, generates per-wheel PWM from a shared
//   timebase, inserts dead time on every direction change, latches duty only at
//   PWM period wraps, and coasts both wheels when the command watchdog trips.
//
//   Optional feature: define MOTOR_RAMP_EN to slew duty by at most RAMP_STEP
//   per PWM period (and restart from 0 after every dead-time interval).
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   cmd_valid      in   1-cycle strobe, pwm_cmd/dir_cmd are new
//   pwm_cmd[15:0]  in   [7:0] left duty, [15:8] right duty
//   dir_cmd[3:0]   in   [1:0] left, [3:2] right: 10 fwd, 01 rev, 00 coast, 11 brake
//   enable         in   0 forces mot_in/mot_pwm low immediately
//   mot_in[3:0]    out  bridge inputs, same layout as dir_cmd
//   mot_pwm[1:0]   out  bridge enable PWM, [0] left, [1] right
//   period_tick    out  1-cycle pulse on each PWM period wrap
//   fault          out  sticky watchdog fault, cleared by the next cmd_valid
// -----------------------------------------------------------------------------
module motor_drive_sequencer #(
    parameter int PRESCALE    = 50,
    parameter int DEAD_CYCLES = 500,
    parameter int WDOG_CYCLES = 0,
    parameter int RAMP_STEP   = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cmd_valid,
    input  logic [15:0] pwm_cmd,
    input  logic [3:0]  dir_cmd,
    input  logic        enable,
    output logic [3:0]  mot_in,
    output logic [1:0]  mot_pwm,
    output logic        period_tick,
    output logic        fault
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'((WDOG_CYCLES > 0) ? (WDOG_CYCLES - 1) : 0);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;
    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    // Move cur toward tgt by at most RAMP_STEP without overshooting.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] step;
        step = 8'(RAMP_STEP);
        if (tgt > cur) begin
            return ((tgt - cur) > step) ? (cur + step) : tgt;
        end else begin
            return ((cur - tgt) > step) ? (cur - step) : tgt;
        end
    endfunction

    logic [PW-1:0]       presc_r, presc_nxt;
    logic [7:0]          cnt_r, cnt_nxt;
    logic                tick_s, wrap_s;
    logic [15:0]         shadow_duty_r;
    logic [3:0]          shadow_dir_r;
    logic [1:0][7:0]     duty_r, duty_nxt;
    logic [1:0]          state_r, state_nxt;
    logic [3:0]          dir_r, dir_nxt;
    logic [3:0]          tgt_r, tgt_nxt;
    logic [1:0][DW-1:0]  dcnt_r, dcnt_nxt;
    logic [WW-1:0]       wcnt_r, wcnt_nxt;
    logic                fault_r, fault_nxt;
    logic                hold_s;
    logic [3:0]          mot_in_r, mot_in_nxt;
    logic [1:0]          mot_pwm_r, mot_pwm_nxt;
    logic                period_tick_r;

    // Shared PWM timebase: prescaler PRESCALE-1..0, count 0..254 advanced per tick.
    always_comb begin
        tick_s = (presc_r == {PW{1'b0}});
        wrap_s = tick_s && (cnt_r == 8'd254);
        if (tick_s) begin
            presc_nxt = PRESC_MAX;
            cnt_nxt   = wrap_s ? 8'd0 : (cnt_r + 8'd1);
        end else begin
            presc_nxt = presc_r - {{(PW-1){1'b0}}, 1'b1};
            cnt_nxt   = cnt_r;
        end
    end

    // Command watchdog; a command in the expiry cycle wins and keeps fault clear.
    always_comb begin
        wcnt_nxt  = wcnt_r;
        fault_nxt = fault_r;
        if (WDOG_CYCLES == 0) begin
            fault_nxt = 1'b0;
        end else if (cmd_valid) begin
            wcnt_nxt  = WDOG_MAX;
            fault_nxt = 1'b0;
        end else if (fault_r) begin
            fault_nxt = 1'b1;
        end else if (wcnt_r == {WW{1'b0}}) begin
            fault_nxt = 1'b1;
        end else begin
            wcnt_nxt = wcnt_r - {{(WW-1){1'b0}}, 1'b1};
        end
        // FSMs stay parked in RUN/coast while faulted, including the clearing cycle,
        // so the clearing command is then seen as an ordinary coast->dir change.
        hold_s = fault_r | fault_nxt;
    end

    // Per-wheel duty latch and RUN/DEAD direction sequencing.
    always_comb begin
        duty_nxt  = duty_r;
        state_nxt = state_r;
        dir_nxt   = dir_r;
        tgt_nxt   = tgt_r;
        dcnt_nxt  = dcnt_r;
        for (int w = 0; w < 2; w++) begin
            if (wrap_s) begin
`ifdef MOTOR_RAMP_EN
                duty_nxt[w] = ramp_toward(duty_r[w], shadow_duty_r[8*w +: 8]);
`else
                duty_nxt[w] = shadow_duty_r[8*w +: 8];
`endif
            end else begin
                duty_nxt[w] = duty_r[w];
            end

            if (hold_s) begin
                state_nxt[w]       = ST_RUN;
                dir_nxt[2*w +: 2]  = DIR_COAST;
                tgt_nxt[2*w +: 2]  = DIR_COAST;
                dcnt_nxt[w]        = {DW{1'b0}};
            end else begin
                case (state_r[w])
                    ST_RUN: begin
                        if (shadow_dir_r[2*w +: 2] != dir_r[2*w +: 2]) begin
                            state_nxt[w]      = ST_DEAD;
                            tgt_nxt[2*w +: 2] = shadow_dir_r[2*w +: 2];
                            dcnt_nxt[w]       = DEAD_MAX;
                        end else begin
                            state_nxt[w] = ST_RUN;
                        end
                    end
                    ST_DEAD: begin
                        // A newer differing target restarts the full dead interval.
                        if (shadow_dir_r[2*w +: 2] != tgt_r[2*w +: 2]) begin
                            tgt_nxt[2*w +: 2] = shadow_dir_r[2*w +: 2];
                            dcnt_nxt[w]       = DEAD_MAX;
                        end else if (dcnt_r[w] == {DW{1'b0}}) begin
                            state_nxt[w]      = ST_RUN;
                            dir_nxt[2*w +: 2] = tgt_r[2*w +: 2];
`ifdef MOTOR_RAMP_EN
                            duty_nxt[w]       = 8'd0;
`endif
                        end else begin
                            dcnt_nxt[w] = dcnt_r[w] - {{(DW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_nxt[w] = ST_RUN;
                    end
                endcase
            end
        end
    end

    // Next bridge outputs, derived from next state so they line up with it.
    always_comb begin
        mot_in_nxt  = 4'b0000;
        mot_pwm_nxt = 2'b00;
        for (int w = 0; w < 2; w++) begin
            if (fault_nxt || (state_nxt[w] == ST_DEAD)) begin
                mot_in_nxt[2*w +: 2] = 2'b00;
                mot_pwm_nxt[w]       = 1'b0;
            end else begin
                mot_in_nxt[2*w +: 2] = dir_nxt[2*w +: 2];
                mot_pwm_nxt[w]       = (dir_nxt[2*w +: 2] == DIR_BRAKE) ? 1'b1
                                                                        : (cnt_nxt < duty_nxt[w]);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc_r       <= PRESC_MAX;
            cnt_r         <= 8'd0;
            shadow_duty_r <= 16'd0;
            shadow_dir_r  <= 4'b0000;
            duty_r        <= '{8'd0, 8'd0};
            state_r       <= {ST_RUN, ST_RUN};
            dir_r         <= 4'b0000;
            tgt_r         <= 4'b0000;
            dcnt_r        <= '{{DW{1'b0}}, {DW{1'b0}}};
            wcnt_r        <= WDOG_MAX;
            fault_r       <= 1'b0;
            mot_in_r      <= 4'b0000;
            mot_pwm_r     <= 2'b00;
            period_tick_r <= 1'b0;
        end else begin
            presc_r       <= presc_nxt;
            cnt_r         <= cnt_nxt;
            if (cmd_valid) begin
                shadow_duty_r <= pwm_cmd;
                shadow_dir_r  <= dir_cmd;
            end
            duty_r        <= duty_nxt;
            state_r       <= state_nxt;
            dir_r         <= dir_nxt;
            tgt_r         <= tgt_nxt;
            dcnt_r        <= dcnt_nxt;
            wcnt_r        <= wcnt_nxt;
            fault_r       <= fault_nxt;
            mot_in_r      <= mot_in_nxt;
            mot_pwm_r     <= mot_pwm_nxt;
            period_tick_r <= wrap_s;
        end
    end

    assign mot_in      = mot_in_r & {4{enable}};
    assign mot_pwm     = mot_pwm_r & {2{enable}};
    assign period_tick = period_tick_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motor_drive_sequencer
//   Randomized + directed stimulus against a cycle-indexed behavioural model.
//   The model derives the PWM count from the elapsed cycle number, tracks
//   dead time as [start,end] cycle intervals and the watchdog as cycles since
//   the last command.
// -----------------------------------------------------------------------------
module tb_motor_drive_sequencer;

    localparam int P    = 2;
    localparam int DEAD = 37;
    localparam int WDOG = 2000;
    localparam int STEP = 8;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        cmd_valid;
    logic [15:0] pwm_cmd;
    logic [3:0]  dir_cmd;
    logic        enable;
    logic [3:0]  mot_in;
    logic [1:0]  mot_pwm;
    logic        period_tick;
    logic        fault;

    motor_drive_sequencer #(
        .PRESCALE    (P),
        .DEAD_CYCLES (DEAD),
        .WDOG_CYCLES (WDOG),
        .RAMP_STEP   (STEP)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid),
        .pwm_cmd       (pwm_cmd),
        .dir_cmd       (dir_cmd),
        .enable        (enable),
        .mot_in        (mot_in),
        .mot_pwm       (mot_pwm),
        .period_tick   (period_tick),
        .fault         (fault)
    );

    always #5 clk_clk = ~clk_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_n, m_last_cmd;
    bit m_fault;
    int m_sduty [2];
    int m_duty  [2];
    int m_dir   [2];
    int m_tgt   [2];
    bit m_dead  [2];
    int m_dstart[2];
    int m_dend  [2];
    bit e_tick;
    int e_in    [2];
    int e_pwm   [2];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, m_n);
        end
    endtask

    function automatic int ramp_model(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP)       return cur + STEP;
        else if (d < -STEP) return cur - STEP;
        else                return tgt;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_last_cmd = 0;
        m_fault = 1'b0;
        e_tick = 1'b0;
        for (int w = 0; w < 2; w++) begin
            m_sduty[w] = 0; m_duty[w] = 0; m_dir[w] = 0; m_tgt[w] = 0;
            m_dead[w] = 1'b0; m_dstart[w] = 0; m_dend[w] = 0;
            e_in[w] = 0; e_pwm[w] = 0;
        end
    endtask

    // Advance the model by one rising edge with the inputs present at that edge.
    task automatic model_edge(input bit cv, input logic [15:0] pc, input logic [3:0] dc);
        bit wrap, old_fault, hold, exited;
        int cnt, nd;
        m_n++;
        wrap = ((m_n % P) == 0) && (((m_n / P) % 255) == 0);
        cnt  = (m_n / P) % 255;
        old_fault = m_fault;
        if (cv) begin
            m_fault = 1'b0;
            m_last_cmd = m_n;
        end else if (m_n - m_last_cmd >= WDOG) begin
            m_fault = 1'b1;
        end
        hold = old_fault || m_fault;
        for (int w = 0; w < 2; w++) begin
            exited = 1'b0;
            if (hold) begin
                m_dir[w] = 0; m_tgt[w] = 0; m_dead[w] = 1'b0;
            end else if (m_dead[w] && (m_n > m_dend[w])) begin
                m_dir[w] = m_tgt[w]; m_dead[w] = 1'b0; exited = 1'b1;
            end
            if (cv) begin
                nd = int'((dc >> (2*w)) & 4'd3);
                if (nd != m_tgt[w]) begin
                    if (!m_dead[w]) begin
                        m_dead[w] = 1'b1;
                        m_dstart[w] = m_n + 1;
                    end
                    m_dend[w] = m_n + DEAD;
                    m_tgt[w] = nd;
                end
            end
            if (wrap) begin
`ifdef MOTOR_RAMP_EN
                m_duty[w] = ramp_model(m_duty[w], m_sduty[w]);
`else
                m_duty[w] = m_sduty[w];
`endif
            end
`ifdef MOTOR_RAMP_EN
            if (exited) m_duty[w] = 0;
`endif
        end
        if (cv) begin
            m_sduty[0] = int'(pc[7:0]);
            m_sduty[1] = int'(pc[15:8]);
        end
        e_tick = wrap;
        for (int w = 0; w < 2; w++) begin
            if (m_fault || (m_dead[w] && (m_n >= m_dstart[w]))) begin
                e_in[w] = 0; e_pwm[w] = 0;
            end else begin
                e_in[w]  = m_dir[w];
                e_pwm[w] = (m_dir[w] == 3) ? 1 : ((cnt < m_duty[w]) ? 1 : 0);
            end
        end
    endtask

    task automatic compare_outputs();
        int xi, xp;
        xi = enable ? (e_in[1] * 4 + e_in[0]) : 0;
        xp = enable ? (e_pwm[1] * 2 + e_pwm[0]) : 0;
        check_eq("mot_in", {12'd0, mot_in}, 16'(xi));
        check_eq("mot_pwm", {14'd0, mot_pwm}, 16'(xp));
        check_eq("period_tick", {15'd0, period_tick}, {15'd0, e_tick});
        check_eq("fault", {15'd0, fault}, {15'd0, m_fault});
    endtask

    task automatic step(input bit cv, input logic [15:0] pc, input logic [3:0] dc, input bit en);
        cmd_valid = cv;
        pwm_cmd   = pc;
        dir_cmd   = dc;
        enable    = en;
        @(posedge clk_clk);
        model_edge(cv, pc, dc);
        @(negedge clk_clk);
        compare_outputs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b1);
    endtask

    function automatic logic [7:0] pick_duty();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0)      return 8'd0;
        else if (r == 1) return 8'd255;
        else             return 8'($urandom);
    endfunction

    initial begin
        bit en_r;
        model_reset();
        reset_reset_n = 1'b0;
        cmd_valid = 1'b0;
        pwm_cmd = 16'd0;
        dir_cmd = 4'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk_clk);
        check_eq("rst_mot_in", {12'd0, mot_in}, 16'd0);
        check_eq("rst_mot_pwm", {14'd0, mot_pwm}, 16'd0);
        check_eq("rst_tick", {15'd0, period_tick}, 16'd0);
        check_eq("rst_fault", {15'd0, fault}, 16'd0);
        reset_reset_n = 1'b1;

        // Left 64 forward, right brake, for three periods.
        step(1'b1, {8'd255, 8'd64}, 4'b1110, 1'b1);
        idle(3 * 255 * P);

        // Left reversal, then a second reversal partway into dead time.
        step(1'b1, {8'd255, 8'd64}, 4'b1101, 1'b1);
        idle(20);
        step(1'b1, {8'd255, 8'd64}, 4'b1110, 1'b1);
        idle(100);

        // Duty 0 and 255, both forward.
        step(1'b1, {8'd0, 8'd255}, 4'b1010, 1'b1);
        idle(3 * 255 * P);

        // Watchdog expiry, then recovery by a command.
        idle(WDOG + 50);
        step(1'b1, {8'd128, 8'd40}, 4'b0110, 1'b1);
        idle(200);

        // Command arriving exactly in the expiry cycle keeps fault clear.
        step(1'b1, {8'd100, 8'd200}, 4'b1001, 1'b1);
        idle(WDOG - 1);
        step(1'b1, {8'd100, 8'd200}, 4'b1001, 1'b1);
        idle(60);

        // Randomized commands with occasional enable drops.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            if ($urandom_range(0, 79) == 0)
                step(1'b1, {pick_duty(), pick_duty()}, 4'($urandom), en_r);
            else
                step(1'b0, 16'($urandom), 4'($urandom), en_r);
        end

        // Asynchronous reset in the middle of dead time.
        step(1'b1, {8'd90, 8'd90}, 4'b0101, 1'b1);
        idle(10);
        step(1'b1, {8'd90, 8'd90}, 4'b1010, 1'b1);
        idle(5);
        reset_reset_n = 1'b0;
        #1;
        check_eq("async_rst_mot_in", {12'd0, mot_in}, 16'd0);
        check_eq("async_rst_mot_pwm", {14'd0, mot_pwm}, 16'd0);
        check_eq("async_rst_fault", {15'd0, fault}, 16'd0);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_clk);
        model_reset();
        reset_reset_n = 1'b1;
        idle(255 * P + 20);
        step(1'b1, {8'd30, 8'd220}, 4'b1110, 1'b1);
        idle(3 * 255 * P);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
